vdecode_sin_cos_phase: RTL and testbench

Decodes a quadrature pair (sinus, cosinus) back into an 8-bit phase and a magnitude. It is the inverse of the video encoder's phase-to-sin/cos lookup and uses the same phase encoding: 256 units per turn, with sinus = A*sin(2*pi*phase/256) and cosinus = A*cos(...). It uses an iterative CORDIC vectoring engine with a start/busy/done handshake. It sits beside the encoder for colour-burst phase measurement and encoder loopback self-test.

---
 rtl/vdecode_sin_cos_phase.sv | 136 +++++++++++++
 tb/tb_vdecode_sin_cos_phase.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vdecode_sin_cos_phase.sv
// Iterative CORDIC vectoring decoder: (cos, sin) pair -> 8-bit phase (256/turn)
// plus magnitude scaled by the uncompensated CORDIC gain.
module vdecode_sin_cos_phase #(
    parameter int ITER = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cos_in,
    input  logic [15:0] sin_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  phase,
    output logic [16:0] magnitude
);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        OUT
    } state_t;

    state_t state, state_next;

    logic signed [17:0] x, y;
    logic        [15:0] z;
    logic        [3:0]  cnt;
    logic               zero_in;

    logic signed [17:0] cos_ext, sin_ext;
    logic signed [17:0] x_sh, y_sh;
    logic        [15:0] z_round;
    logic               force_zero;

    // Arctangent table in 65536-units/turn, decoded from the counter.
    // NOTE: a constant case-decoded table is pure logic, so it needs no reset.
    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd8192;
            4'd1:    return 16'd4836;
            4'd2:    return 16'd2555;
            4'd3:    return 16'd1297;
            4'd4:    return 16'd651;
            4'd5:    return 16'd326;
            4'd6:    return 16'd163;
            4'd7:    return 16'd81;
            4'd8:    return 16'd41;
            4'd9:    return 16'd20;
            4'd10:   return 16'd10;
            4'd11:   return 16'd5;
            4'd12:   return 16'd3;
            4'd13:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    assign cos_ext = {{2{cos_in[15]}}, cos_in};
    assign sin_ext = {{2{sin_in[15]}}, sin_in};
    assign x_sh    = x >>> cnt;
    assign y_sh    = y >>> cnt;
    assign z_round = z + 16'd128;
    // x cannot go negative after pre-rotation; treat it as a null vector if it ever did.
    assign force_zero = zero_in | x[17];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ROT;
            ROT:     if (cnt == 4'(ITER - 1)) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            zero_in   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase     <= '0;
            magnitude <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Fold the left half-plane onto the right so CORDIC converges.
                        if (cos_in[15]) begin
                            x <= -cos_ext;
                            y <= -sin_ext;
                            z <= 16'h8000;
                        end else begin
                            x <= cos_ext;
                            y <= sin_ext;
                            z <= 16'h0000;
                        end
                        cnt     <= '0;
                        zero_in <= (cos_in == 16'd0) && (sin_in == 16'd0);
                        busy    <= 1'b1;
                    end
                end
                ROT: begin
                    if (!y[17]) begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_lut(cnt);
                    end else begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_lut(cnt);
                    end
                    cnt <= cnt + 4'd1;
                end
                OUT: begin
                    phase     <= force_zero ? 8'd0  : z_round[15:8];
                    magnitude <= force_zero ? 17'd0 : x[16:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vdecode_sin_cos_phase.sv
// Directed self-checking bench for vdecode_sin_cos_phase (ITER = 12).
module tb_vdecode_sin_cos_phase;

    localparam int ITER = 12;
    localparam int LAT  = ITER + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cos_in;
    logic [15:0] sin_in;
    logic        busy;
    logic        done;
    logic [7:0]  phase;
    logic [16:0] magnitude;

    int checks = 0;
    int errors = 0;

    vdecode_sin_cos_phase #(.ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cos_in    (cos_in),
        .sin_in    (sin_in),
        .busy      (busy),
        .done      (done),
        .phase     (phase),
        .magnitude (magnitude)
    );

    always #5 clk = ~clk;

    // Drive and sample 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Present inputs with start for the accepting edge, then drop start.
    task automatic start_conv(input logic [15:0] c, input logic [15:0] s);
        cos_in = c;
        sin_in = s;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Bounded wait for done; n counts edges after the accepting edge.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 60);
    endtask

    // One full conversion; lat is edges from the accepting edge (inclusive) to done.
    task automatic convert(input string tag, input logic [15:0] c, input logic [15:0] s,
                           input int exp_phase, input int mag_lo, input int mag_hi);
        int n;
        start_conv(c, s);
        wait_done(n);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_lat"}, n + 1, LAT);
        check({tag, "_phase"}, int'(phase), exp_phase);
        check_rng({tag, "_mag"}, int'(magnitude), mag_lo, mag_hi);
    endtask

    initial begin
        int n;
        int pulses;
        int diff;
        int ci, si;
        real th;

        rst    = 1'b1;
        start  = 1'b0;
        cos_in = '0;
        sin_in = '0;

        // Reset then idle
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_mag", int'(magnitude), 0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) pulses++;
        end
        check("idle_no_done", pulses, 0);

        // Cardinal axes, 45 degrees and rounding wrap
        convert("ax_0",   16'h6000, 16'h0000, 0,   40455, 40487);
        convert("ax_64",  16'h0000, 16'h6000, 64,  40455, 40487);
        convert("ax_128", 16'hA000, 16'h0000, 128, 40455, 40487);
        convert("ax_192", 16'h0000, 16'hA000, 192, 40455, 40487);
        convert("diag_32", 16'h43E2, 16'h43E2, 32, 40400, 40550);
        convert("wrap_0",  16'h6000, 16'hFFFF, 0,   40455, 40487);
        convert("wrap_128", 16'hA000, 16'h0001, 128, 40455, 40487);

        // start mid-rotation with different inputs must be ignored
        start_conv(16'h6000, 16'h0000);
        for (int i = 0; i < 4; i++) tick();
        cos_in = 16'h0000;
        sin_in = 16'h6000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("midrot_busy", int'(busy), 1);
        wait_done(n);
        check("midrot_done", int'(done), 1);
        check("midrot_lat", n + 6, LAT);
        check("midrot_phase", int'(phase), 0);
        tick();
        check("midrot_no_restart", int'(busy), 0);

        // start held high: done every LAT edges, busy low only in done cycles
        cos_in = 16'h0000;
        sin_in = 16'h6000;
        start  = 1'b1;
        tick();
        for (int k = 1; k <= 3 * LAT - 1; k++) begin
            tick();
            check($sformatf("held_done_%0d", k), int'(done), (k % LAT == LAT - 1) ? 1 : 0);
            check($sformatf("held_busy_%0d", k), int'(busy), (k % LAT == LAT - 1) ? 0 : 1);
        end
        start = 1'b0;
        check("held_phase", int'(phase), 64);
        tick();

        // reset at iteration 5 discards the conversion and clears outputs
        start_conv(16'h43E2, 16'h43E2);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_phase", int'(phase), 0);
        check("mid_rst_mag", int'(magnitude), 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("mid_rst_quiet", pulses, 0);
        convert("after_rst", 16'h43E2, 16'h43E2, 32, 40400, 40550);

        // Boundaries
        convert("zero", 16'h0000, 16'h0000, 0, 0, 0);
        convert("corner", 16'h8000, 16'h8000, 160, 76268, 76332);

        // Sweep through an ideal encoder model, A = 0x6000
        for (int p = 0; p < 256; p++) begin
            th = 2.0 * 3.14159265358979 * real'(p) / 256.0;
            ci = $rtoi($floor(24576.0 * $cos(th) + 0.5));
            si = $rtoi($floor(24576.0 * $sin(th) + 0.5));
            start_conv(16'(ci), 16'(si));
            wait_done(n);
            diff = (int'(phase) - p + 256) % 256;
            check_rng($sformatf("sweep_%0d_done", p), int'(done), 1, 1);
            check_rng($sformatf("sweep_%0d", p), (diff + 1) % 256, 0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
